// File: rtl/disp_mode_scheduler_if.sv
// rtl/disp_mode_scheduler_if.sv - source digits, control strobes and segment output of the display scheduler
interface disp_mode_scheduler_if;
  logic        frame_start;
  logic        mode_next;
  logic        edit_en;
  logic [1:0]  edit_field;
  logic [35:0] clk_bcd;
  logic [35:0] sw_bcd;
  logic [35:0] tmr_bcd;
  logic [1:0]  mode;
  logic [2:0]  src_sel;
  logic [62:0] con;

  modport master (
    output frame_start, mode_next, edit_en, edit_field, clk_bcd, sw_bcd, tmr_bcd,
    input  mode, src_sel, con
  );

  modport slave (
    input  frame_start, mode_next, edit_en, edit_field, clk_bcd, sw_bcd, tmr_bcd,
    output mode, src_sel, con
  );
endinterface

// File: rtl/disp_mode_scheduler.sv
// rtl/disp_mode_scheduler.sv - mode FSM, BCD to 7-segment, set-mode blink, frame-latched con
// Optional LEAD_ZERO_BLANK_EN blanks a zero digit A in CLOCK mode.
module disp_mode_scheduler #(
  parameter int BLINK_FRAMES = 30,
  parameter int BLINK_W      = 6
) (
  input  logic                 CLK,
  input  logic                 RST_BTN,
  disp_mode_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    CLOCK     = 2'd0,
    STOPWATCH = 2'd1,
    TIMER     = 2'd2
  } mode_e;

  typedef enum logic {
    VISIBLE = 1'b0,
    HIDDEN  = 1'b1
  } phase_e;

  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  mode_e               state_q, state_d;
  phase_e              phase_q, phase_d;
  logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic [35:0]         src_bcd;
  logic                lead_blank;
  logic [62:0]         frame_con;
  logic [62:0]         con_q;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0000100;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Digit k sits at con[62-7k -: 7]; a hidden edit field blanks digits 2f and 2f+1.
  function automatic logic [62:0] render(
    input logic [35:0] src,
    input logic [1:0]  field,
    input logic        hide,
    input logic        blank_a
  );
    logic [6:0] pat;
    render = '1;
    for (int k = 0; k < 9; k++) begin
      pat = seg7(src[35-4*k -: 4]);
      if (hide && field != 2'd3 && (k / 2) == int'(field)) pat = 7'b1111111;
      if (k == 0 && blank_a) pat = 7'b1111111;
      render[62-7*k -: 7] = pat;
    end
  endfunction

  always_ff @(posedge CLK) begin
    if (!RST_BTN) begin
      state_q     <= CLOCK;
      phase_q     <= VISIBLE;
      blink_cnt_q <= '0;
      con_q       <= '1;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      blink_cnt_q <= blink_cnt_d;
      if (bus.frame_start) con_q <= frame_con;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CLOCK:     if (bus.mode_next && !bus.edit_en) state_d = STOPWATCH;
      STOPWATCH: if (bus.mode_next && !bus.edit_en) state_d = TIMER;
      TIMER:     if (bus.mode_next && !bus.edit_en) state_d = CLOCK;
      default:   state_d = CLOCK;
    endcase
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (!bus.edit_en) begin
      blink_cnt_d = '0;
      phase_d     = VISIBLE;
    end else if (bus.frame_start) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        phase_d     = (phase_q == HIDDEN) ? VISIBLE : HIDDEN;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    case (state_q)
      STOPWATCH: src_bcd = bus.sw_bcd;
      TIMER:     src_bcd = bus.tmr_bcd;
      default:   src_bcd = bus.clk_bcd;
    endcase
  end

`ifdef LEAD_ZERO_BLANK_EN
  assign lead_blank = (state_q == CLOCK) && (src_bcd[35:32] == 4'd0);
`else
  assign lead_blank = 1'b0;
`endif

  // The frame uses the post-toggle phase so a toggle and frame_start in one cycle agree.
  assign frame_con = render(src_bcd, bus.edit_field, phase_d == HIDDEN, lead_blank);

  always_comb begin
    case (state_q)
      STOPWATCH: bus.src_sel = 3'b010;
      TIMER:     bus.src_sel = 3'b100;
      default:   bus.src_sel = 3'b001;
    endcase
  end

  assign bus.mode = state_q;
  assign bus.con  = con_q;

endmodule
